// File: rtl/pdp8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdp8_pkg                                                             |
// | Shared widths, opcode structs, FSM states and OPR group codes for    |
// | the PDP-8 instruction fetch/decode front end.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_MEM_WAIT  = 3'd2,
    S_DECODE    = 3'd3,
    S_EXEC_WAIT = 3'd4
  } fsm_state_e;

  typedef struct packed {
    logic       AND;
    logic       TAD;
    logic       ISZ;
    logic       DCA;
    logic       JMS;
    logic       JMP;
    logic [8:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic CLA2;
  } pdp_op7_opcode_s;

  localparam logic [2:0] c_OPC_AND = 3'd0;
  localparam logic [2:0] c_OPC_TAD = 3'd1;
  localparam logic [2:0] c_OPC_ISZ = 3'd2;
  localparam logic [2:0] c_OPC_DCA = 3'd3;
  localparam logic [2:0] c_OPC_JMS = 3'd4;
  localparam logic [2:0] c_OPC_JMP = 3'd5;
  localparam logic [2:0] c_OPC_IOT = 3'd6;
  localparam logic [2:0] c_OPC_OPR = 3'd7;

  localparam logic [DATA_WIDTH-1:0] c_OP7_NOP     = 12'o7000;
  localparam logic [DATA_WIDTH-1:0] c_OP7_IAC     = 12'o7001;
  localparam logic [DATA_WIDTH-1:0] c_OP7_RAL     = 12'o7004;
  localparam logic [DATA_WIDTH-1:0] c_OP7_RTL     = 12'o7006;
  localparam logic [DATA_WIDTH-1:0] c_OP7_RAR     = 12'o7010;
  localparam logic [DATA_WIDTH-1:0] c_OP7_RTR     = 12'o7012;
  localparam logic [DATA_WIDTH-1:0] c_OP7_CML     = 12'o7020;
  localparam logic [DATA_WIDTH-1:0] c_OP7_CMA     = 12'o7040;
  localparam logic [DATA_WIDTH-1:0] c_OP7_CIA     = 12'o7041;
  localparam logic [DATA_WIDTH-1:0] c_OP7_CLL     = 12'o7100;
  localparam logic [DATA_WIDTH-1:0] c_OP7_CLA1    = 12'o7200;
  localparam logic [DATA_WIDTH-1:0] c_OP7_CLA_CLL = 12'o7300;
  localparam logic [DATA_WIDTH-1:0] c_OP7_HLT     = 12'o7402;
  localparam logic [DATA_WIDTH-1:0] c_OP7_OSR     = 12'o7404;
  localparam logic [DATA_WIDTH-1:0] c_OP7_SKP     = 12'o7410;
  localparam logic [DATA_WIDTH-1:0] c_OP7_SNL     = 12'o7420;
  localparam logic [DATA_WIDTH-1:0] c_OP7_SZL     = 12'o7430;
  localparam logic [DATA_WIDTH-1:0] c_OP7_SZA     = 12'o7440;
  localparam logic [DATA_WIDTH-1:0] c_OP7_SNA     = 12'o7450;
  localparam logic [DATA_WIDTH-1:0] c_OP7_SMA     = 12'o7500;
  localparam logic [DATA_WIDTH-1:0] c_OP7_SPA     = 12'o7510;
  localparam logic [DATA_WIDTH-1:0] c_OP7_CLA2    = 12'o7600;

  // Memory-reference decode; IOT and OPR words yield an all-zero struct.
  function automatic pdp_mem_opcode_s mem_decode(input logic [DATA_WIDTH-1:0] word);
    pdp_mem_opcode_s d;
    d = '0;
    case (word[11:9])
      c_OPC_AND: d.AND = 1'b1;
      c_OPC_TAD: d.TAD = 1'b1;
      c_OPC_ISZ: d.ISZ = 1'b1;
      c_OPC_DCA: d.DCA = 1'b1;
      c_OPC_JMS: d.JMS = 1'b1;
      c_OPC_JMP: d.JMP = 1'b1;
      default:   d     = '0;
    endcase
    if (word[11:9] < c_OPC_IOT) begin
      d.mem_inst_addr = word[8:0];
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_decode_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_decode_if                                                |
// | Instruction memory read bus between the fetch unit and memory.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface instr_fetch_decode_if;
  import pdp8_pkg::*;

  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;

  modport master (
    output ifu_rd_req,
    output ifu_rd_addr,
    input  ifu_rd_data
  );

  modport slave (
    input  ifu_rd_req,
    input  ifu_rd_addr,
    output ifu_rd_data
  );

endinterface
`default_nettype wire

// File: rtl/pdp8_op7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdp8_op7_decode                                                      |
// | Combinational OPR (7xxx) decode into a one-hot struct plus a flag    |
// | for words that are not one of the recognised microcodes.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pdp8_op7_decode
  import pdp8_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_instr,
  output pdp_op7_opcode_s       o_op7,
  output logic                  o_illegal
);

  always_comb begin
    o_op7     = '0;
    o_illegal = 1'b0;
    case (i_instr)
      c_OP7_NOP:     o_op7.NOP     = 1'b1;
      c_OP7_IAC:     o_op7.IAC     = 1'b1;
      c_OP7_RAL:     o_op7.RAL     = 1'b1;
      c_OP7_RTL:     o_op7.RTL     = 1'b1;
      c_OP7_RAR:     o_op7.RAR     = 1'b1;
      c_OP7_RTR:     o_op7.RTR     = 1'b1;
      c_OP7_CML:     o_op7.CML     = 1'b1;
      c_OP7_CMA:     o_op7.CMA     = 1'b1;
      c_OP7_CIA:     o_op7.CIA     = 1'b1;
      c_OP7_CLL:     o_op7.CLL     = 1'b1;
      c_OP7_CLA1:    o_op7.CLA1    = 1'b1;
      c_OP7_CLA_CLL: o_op7.CLA_CLL = 1'b1;
      c_OP7_HLT:     o_op7.HLT     = 1'b1;
      c_OP7_OSR:     o_op7.OSR     = 1'b1;
      c_OP7_SKP:     o_op7.SKP     = 1'b1;
      c_OP7_SNL:     o_op7.SNL     = 1'b1;
      c_OP7_SZL:     o_op7.SZL     = 1'b1;
      c_OP7_SZA:     o_op7.SZA     = 1'b1;
      c_OP7_SNA:     o_op7.SNA     = 1'b1;
      c_OP7_SMA:     o_op7.SMA     = 1'b1;
      c_OP7_SPA:     o_op7.SPA     = 1'b1;
      c_OP7_CLA2:    o_op7.CLA2    = 1'b1;
      default:       o_illegal     = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_decode                                                   |
// | PDP-8 fetch/decode front end: one read per instruction, registered   |
// | decode held until the execution unit has stalled and released.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_fetch_decode
  import pdp8_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  instr_fetch_decode_if.master  mem_bus,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  decode_valid,
  output logic                  illegal_op
);

  fsm_state_e            r_state;
  fsm_state_e            w_next_state;
  logic                  w_rd_req;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  logic                  r_rst_done;
  logic                  r_seen_stall;
  logic [ADDR_WIDTH-1:0] r_fetch_addr;
  logic [DATA_WIDTH-1:0] r_ir;

  logic [ADDR_WIDTH-1:0] r_base_addr;
  pdp_mem_opcode_s       r_mem_op;
  pdp_op7_opcode_s       r_op7_op;
  logic                  r_decode_valid;
  logic                  r_illegal;

  pdp_op7_opcode_s       w_op7;
  logic                  w_op7_illegal;
  logic [2:0]            w_opc;
  logic                  w_illegal;

  pdp8_op7_decode u_op7_decode (
    .i_instr   (r_ir),
    .o_op7     (w_op7),
    .o_illegal (w_op7_illegal)
  );

  assign w_opc     = r_ir[11:9];
  assign w_illegal = (w_opc == c_OPC_IOT) || ((w_opc == c_OPC_OPR) && w_op7_illegal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // r_rst_done holds IDLE for one extra edge after reset release.
  always_comb begin
    w_next_state = r_state;
    w_rd_req     = 1'b0;
    w_rd_addr    = '0;
    case (r_state)
      S_IDLE: begin
        if (r_rst_done && !stall) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_rd_req     = 1'b1;
        w_rd_addr    = PC_value;
        w_next_state = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_next_state = S_EXEC_WAIT;
      end
      S_EXEC_WAIT: begin
        if (r_seen_stall && !stall) begin
          w_next_state = S_FETCH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_done     <= 1'b0;
      r_seen_stall   <= 1'b0;
      r_fetch_addr   <= '0;
      r_ir           <= '0;
      r_base_addr    <= '0;
      r_mem_op       <= '0;
      r_op7_op       <= '0;
      r_decode_valid <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      r_rst_done     <= 1'b1;
      r_decode_valid <= 1'b0;
      // Flag only survives while the FSM stays in EXEC_WAIT.
      r_seen_stall   <= (r_state == S_EXEC_WAIT) && (w_next_state == S_EXEC_WAIT)
                        && (r_seen_stall || stall);
      if (r_state == S_FETCH) begin
        r_fetch_addr <= PC_value;
      end
      if (r_state == S_MEM_WAIT) begin
        r_ir <= mem_bus.ifu_rd_data;
      end
      if (r_state == S_DECODE) begin
        r_base_addr    <= r_fetch_addr;
        r_mem_op       <= mem_decode(r_ir);
        r_op7_op       <= w_op7;
        r_illegal      <= w_illegal;
        r_decode_valid <= 1'b1;
      end
    end
  end

  assign mem_bus.ifu_rd_req  = w_rd_req;
  assign mem_bus.ifu_rd_addr = w_rd_addr;
  assign base_addr           = r_base_addr;
  assign pdp_mem_opcode      = r_mem_op;
  assign pdp_op7_opcode      = r_op7_op;
  assign decode_valid        = r_decode_valid;
  assign illegal_op          = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch_decode                                                |
// | Self-checking bench for instr_fetch_decode with a table-driven model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instr_fetch_decode;
  import pdp8_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic [11:0]     PC_value;
  logic [11:0]     mem_word;
  logic [11:0]     base_addr;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;
  logic            decode_valid;
  logic            illegal_op;

  int checks = 0;
  int fails  = 0;

  logic [11:0] op7_codes [22] = '{
    12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012, 12'o7020, 12'o7040,
    12'o7041, 12'o7100, 12'o7200, 12'o7300, 12'o7402, 12'o7404, 12'o7410, 12'o7420,
    12'o7430, 12'o7440, 12'o7450, 12'o7500, 12'o7510, 12'o7600};

  instr_fetch_decode_if bus ();

  instr_fetch_decode dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .PC_value       (PC_value),
    .mem_bus        (bus),
    .base_addr      (base_addr),
    .pdp_mem_opcode (pdp_mem_opcode),
    .pdp_op7_opcode (pdp_op7_opcode),
    .decode_valid   (decode_valid),
    .illegal_op     (illegal_op)
  );

  always #5 clk = ~clk;

  // Memory: requested word the cycle after a read strobe, noise otherwise.
  always @(posedge clk) begin
    if (bus.ifu_rd_req === 1'b1) bus.ifu_rd_data <= mem_word;
    else                         bus.ifu_rd_data <= 12'($urandom);
  end

  // Reference: top octal digit selects class; OPR words looked up in the code table.
  function automatic void model(input logic [11:0] w, output logic [14:0] em,
                                output logic [21:0] e7, output logic eil);
    int op;
    op  = int'(w[11:9]);
    em  = '0;
    e7  = '0;
    eil = 1'b0;
    if (op <= 5) begin
      em[14-op] = 1'b1;
      em[8:0]   = w[8:0];
    end else if (op == 6) begin
      eil = 1'b1;
    end else begin
      eil = 1'b1;
      for (int i = 0; i < 22; i++) begin
        if (op7_codes[i] == w) begin
          e7[21-i] = 1'b1;
          eil      = 1'b0;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_exec(input int n);
    stall = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (bus.ifu_rd_req !== 1'b0) begin
        fails++;
        $display("FAIL req_during_stall: ifu_rd_req=%b required 0", bus.ifu_rd_req);
      end
    end
    stall = 1'b0;
  endtask

  task automatic fetch_and_check(input logic [11:0] pc, input logic [11:0] word, output int lat);
    logic [14:0] em;
    logic [21:0] e7;
    logic        eil;
    logic [14:0] mv;
    logic [21:0] ov;
    model(word, em, e7, eil);
    PC_value = pc;
    mem_word = word;
    lat      = 0;
    while (bus.ifu_rd_req !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (bus.ifu_rd_req !== 1'b1) begin
      fails++;
      $display("FAIL fetch_timeout: ifu_rd_req=%b after %0d cycles, required 1", bus.ifu_rd_req, lat);
      return;
    end
    checks++;
    if (bus.ifu_rd_addr !== pc) begin
      fails++;
      $display("FAIL rd_addr: got %o required %o", bus.ifu_rd_addr, pc);
    end
    tick();
    PC_value = 12'($urandom);
    checks++;
    if (bus.ifu_rd_req !== 1'b0) begin
      fails++;
      $display("FAIL req_one_cycle: ifu_rd_req=%b at F+1 required 0", bus.ifu_rd_req);
    end
    tick();
    checks++;
    if (decode_valid !== 1'b0) begin
      fails++;
      $display("FAIL early_valid: decode_valid=%b at F+2 required 0", decode_valid);
    end
    tick();
    mv = pdp_mem_opcode;
    ov = pdp_op7_opcode;
    checks++;
    if (decode_valid !== 1'b1) begin
      fails++;
      $display("FAIL valid_f3: decode_valid=%b at F+3 required 1 (word %o)", decode_valid, word);
    end
    checks++;
    if (base_addr !== pc) begin
      fails++;
      $display("FAIL base_addr: got %o required %o", base_addr, pc);
    end
    checks++;
    if (mv !== em) begin
      fails++;
      $display("FAIL mem_opcode: word %o got %h required %h", word, mv, em);
    end
    checks++;
    if (ov !== e7) begin
      fails++;
      $display("FAIL op7_opcode: word %o got %h required %h", word, ov, e7);
    end
    checks++;
    if (illegal_op !== eil) begin
      fails++;
      $display("FAIL illegal_op: word %o got %b required %b", word, illegal_op, eil);
    end
    tick();
    checks++;
    if (decode_valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_pulse: decode_valid=%b at F+4 required 0", decode_valid);
    end
    checks++;
    if ({pdp_mem_opcode, pdp_op7_opcode, illegal_op, base_addr} !== {em, e7, eil, pc}) begin
      fails++;
      $display("FAIL hold: got %h required %h",
               {pdp_mem_opcode, pdp_op7_opcode, illegal_op, base_addr}, {em, e7, eil, pc});
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    stall    = 1'b0;
    PC_value = 12'o0200;
    mem_word = 12'o1123;
    repeat (3) tick();
    checks++;
    if ({bus.ifu_rd_req, bus.ifu_rd_addr, base_addr, pdp_mem_opcode, pdp_op7_opcode,
         decode_valid, illegal_op} !== '0) begin
      fails++;
      $display("FAIL reset_state: got %h required 0", {bus.ifu_rd_req, bus.ifu_rd_addr,
               base_addr, pdp_mem_opcode, pdp_op7_opcode, decode_valid, illegal_op});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.ifu_rd_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_edge: ifu_rd_req=%b required 0", bus.ifu_rd_req);
    end
  endtask

  task automatic test_basic_fetch();
    int lat;
    fetch_and_check(12'o0200, 12'o1123, lat);
  endtask

  task automatic test_op7_sweep();
    int lat;
    for (int i = 0; i < 22; i++) begin
      release_exec(1 + int'($urandom_range(0, 2)));
      fetch_and_check(12'($urandom), op7_codes[i], lat);
    end
  endtask

  task automatic test_illegal();
    logic [11:0] words [4];
    int lat;
    words[0] = 12'o6001;
    words[1] = 12'o7777;
    words[2] = 12'o7003;
    words[3] = {3'o6, 9'($urandom)};
    for (int i = 0; i < 4; i++) begin
      release_exec(1);
      fetch_and_check(12'($urandom), words[i], lat);
    end
  endtask

  task automatic test_stall();
    int lat;
    release_exec(5);
    fetch_and_check(12'o4321, 12'o2345, lat);
    checks++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL stall_release: req after %0d cycles required 1", lat);
    end
  endtask

  task automatic test_reset_mem_wait();
    int n;
    release_exec(1);
    fetch_and_check(12'o0100, 12'o3177, n);
    release_exec(1);
    PC_value = 12'o0333;
    mem_word = 12'o5020;
    n = 0;
    while (bus.ifu_rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.ifu_rd_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_fetch_timeout: ifu_rd_req=%b required 1", bus.ifu_rd_req);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.ifu_rd_req, bus.ifu_rd_addr, base_addr, pdp_mem_opcode, pdp_op7_opcode,
         decode_valid, illegal_op} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %h required 0", {bus.ifu_rd_req, bus.ifu_rd_addr,
               base_addr, pdp_mem_opcode, pdp_op7_opcode, decode_valid, illegal_op});
    end
    mem_word = 12'o1234;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.ifu_rd_req !== 1'b0 || pdp_mem_opcode.JMP !== 1'b0) begin
      fails++;
      $display("FAIL rst_restart: req=%b jmp=%b required 0/0", bus.ifu_rd_req, pdp_mem_opcode.JMP);
    end
    fetch_and_check(12'o0444, 12'o1234, n);
  endtask

  task automatic test_random();
    int lat;
    logic [11:0] w;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) w = op7_codes[$urandom_range(0, 21)];
      else                           w = 12'($urandom);
      release_exec(1 + int'($urandom_range(0, 3)));
      fetch_and_check(12'($urandom), w, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_op7_sweep();
    test_illegal();
    test_stall();
    test_reset_mem_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port stall, input, 1: execution unit busy; high while the current instruction executes.
REQ-004 SHALL have port PC_value, input, ADDR_WIDTH (12): address of the next instruction.
REQ-005 SHALL have port ifu_rd_req, output, 1: memory read strobe.
REQ-006 SHALL have port ifu_rd_addr, output, ADDR_WIDTH: memory read address.
REQ-007 SHALL have port ifu_rd_data, input, DATA_WIDTH (12): read data, valid the cycle after ifu_rd_req.
REQ-008 SHALL have port base_addr, output, ADDR_WIDTH: address the decoded instruction was fetched from.
REQ-009 SHALL have port pdp_mem_opcode, output, pdp_mem_opcode_s: one-hot AND/TAD/ISZ/DCA/JMS/JMP plus mem_inst_addr[8:0].
REQ-010 SHALL have port pdp_op7_opcode, output, pdp_op7_opcode_s: 22 one-hot fields, NOP..CLA2 order.
REQ-011 SHALL have port decode_valid, output, 1: one-cycle pulse when new decode outputs appear.
REQ-012 SHALL have port illegal_op, output, 1: registered with decode outputs; high for opcode 6 or unlisted 7xxx.

Function
REQ-013 SHALL implement FSM IDLE, FETCH, MEM_WAIT, DECODE, EXEC_WAIT.
REQ-014 IDLE SHALL go to FETCH when stall=0; otherwise stay.
REQ-015 FETCH SHALL drive ifu_rd_req=1 and ifu_rd_addr=PC_value for exactly one cycle, latch PC_value as fetch address, go to MEM_WAIT.
REQ-016 MEM_WAIT SHALL latch ifu_rd_data into the instruction register, go to DECODE.
REQ-017 DECODE SHALL register base_addr, both opcode structs and illegal_op, pulse decode_valid, go to EXEC_WAIT.
REQ-018 Latency: with ifu_rd_req high in cycle F, decode outputs and decode_valid SHALL be visible in cycle F+3.
REQ-019 EXEC_WAIT SHALL hold all decode outputs; SHALL go to FETCH in the cycle after stall is sampled 1 and later 0 (a seen-stall flag, cleared on leaving).
REQ-020 Bits[11:9]=0..5 SHALL set the matching mem one-hot bit, mem_inst_addr=bits[8:0], and op7 all zero.
REQ-021 Bits[11:9]=7 SHALL set mem struct all zero and exactly one op7 bit for 7000,7001,7004,7006,7010,7012,7020,7040,7041,7100,7200,7300,7402,7404,7410,7420,7430,7440,7450,7500,7510,7600 (octal).
REQ-022 Opcode 6 or any other 7xxx SHALL give both structs all zero and illegal_op=1.
REQ-023 ifu_rd_req SHALL never be high outside FETCH; at most one outstanding read.
REQ-024 PC_value changes outside FETCH SHALL have no effect; PC wrap 7777->0000 needs no special handling.

Reset
REQ-025 reset SHALL force state IDLE and clear ifu_rd_req, ifu_rd_addr, base_addr, both structs, decode_valid, illegal_op, instruction register and seen-stall flag, immediately.
REQ-026 reset in any state, including MEM_WAIT, SHALL discard the pending read; returning ifu_rd_data SHALL be ignored.
REQ-027 After reset deassertion the first fetch SHALL start no earlier than the second rising edge.

Structure
REQ-028 ADDR_WIDTH, DATA_WIDTH, pdp_mem_opcode_s, pdp_op7_opcode_s, state enum and op7 octal constants SHALL live in pdp8_pkg.
REQ-029 op7 decode SHALL be a combinational sub-module pdp8_op7_decode (12-bit word in, struct plus illegal flag out).

Verification
REQ-030 PC=0200, data 1123 -> req 1 cycle at addr 0200; F+3: TAD=1, mem_inst_addr=123, base_addr=0200, decode_valid 1 cycle.
REQ-031 Sweep all 22 op7 codes -> exactly the matching op7 field set, mem struct zero, illegal_op=0.
REQ-032 Data 6001 and 7777 -> both structs zero, illegal_op=1.
REQ-033 In EXEC_WAIT hold stall=1 for 5 cycles then 0 -> no req during stall; next req cycle after stall falls, at new PC_value.
REQ-034 reset asserted in MEM_WAIT with data 5020 -> outputs zero immediately, JMP never reported, fetch restarts from IDLE.
